key_entry: RTL and testbench

Downstream consumer of the 4x4 keypad scanner's debounced `press` / key-code outputs. Converts each distinct key press into one editing action on a multi-digit BCD entry buffer: digit shift-in, backspace, clear, enter, and tare/zero commands. On enter, it presents the entered value to the weighing-scale control logic with a valid/ack handshake. All logic runs in the scanner's clock domain, so no synchronisers are used.

---
 rtl/key_entry.sv | 129 ++++++++++++
 tb/tb_key_entry.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_entry.sv
// key_entry
//
// Turns debounced keypad presses into editing actions on a multi-digit BCD
// entry buffer. Digits shift in from the least-significant end. Backspace
// drops the newest digit, and clear empties the buffer. Enter commits a
// non-empty buffer to the scale controller through a Valid/Ack handshake.
// Tare and zero keys produce single-cycle command pulses.
//
// Ports:
//   Clock    - system clock, shared with the keypad scanner
//   Reset_n  - asynchronous active-low reset
//   press    - debounced key-held flag from the scanner
//   CodeIn   - key code: 0-9 digit, A backspace, B enter, C clear,
//              D tare, E zero, F none
//   Ack      - consumer has taken Value (only meaningful while Valid=1)
//   Value    - BCD entry buffer, least-significant digit in [3:0]
//   Count    - number of digits currently entered
//   Valid    - committed value waiting for Ack
//   Tare     - one-cycle pulse on key D
//   Zero     - one-cycle pulse on key E
//   Err      - one-cycle pulse when an action is rejected

module key_entry #(
  parameter int DIGITS = 4
) (
  input  logic                           Clock,
  input  logic                           Reset_n,
  input  logic                           press,
  input  logic [3:0]                     CodeIn,
  input  logic                           Ack,
  output logic [4*DIGITS-1:0]            Value,
  output logic [$clog2(DIGITS+1)-1:0]    Count,
  output logic                           Valid,
  output logic                           Tare,
  output logic                           Zero,
  output logic                           Err
);

  localparam int CW = $clog2(DIGITS+1);
  localparam logic [CW-1:0] MaxCount = CW'(DIGITS);
  localparam logic [CW-1:0] One      = CW'(1);

  localparam logic [3:0] KeyBack  = 4'hA;
  localparam logic [3:0] KeyEnter = 4'hB;
  localparam logic [3:0] KeyClear = 4'hC;
  localparam logic [3:0] KeyTare  = 4'hD;
  localparam logic [3:0] KeyZero  = 4'hE;

  typedef enum logic {EDIT, HOLD} state_t;

  state_t state;
  logic   pressD;
  logic   pressEdge;

  // A key acts only on the rising edge of press. This makes a long hold
  // count once, and a single low cycle between presses is enough to re-arm.
  assign pressEdge = press & ~pressD;

  // Main controller. The command pulses default low every cycle, so each one
  // lasts exactly one clock. In HOLD, press edges are still tracked through
  // pressD, so a key held across the Ack cycle is consumed, not replayed.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= EDIT;
      pressD <= 1'b0;
      Value  <= '0;
      Count  <= '0;
      Valid  <= 1'b0;
      Tare   <= 1'b0;
      Zero   <= 1'b0;
      Err    <= 1'b0;
    end else begin
      pressD <= press;
      Tare   <= 1'b0;
      Zero   <= 1'b0;
      Err    <= 1'b0;
      case (state)
        EDIT: begin
          if (pressEdge) begin
            if (CodeIn <= 4'd9) begin
              if (Count < MaxCount) begin
                Value <= {Value[4*DIGITS-5:0], CodeIn};
                Count <= Count + One;
              end else begin
                Err <= 1'b1;
              end
            end else begin
              case (CodeIn)
                KeyBack: begin
                  if (Count != '0) begin
                    Value <= {4'h0, Value[4*DIGITS-1:4]};
                    Count <= Count - One;
                  end else begin
                    Err <= 1'b1;
                  end
                end
                KeyEnter: begin
                  if (Count != '0) begin
                    state <= HOLD;
                    Valid <= 1'b1;
                  end else begin
                    Err <= 1'b1;
                  end
                end
                KeyClear: begin
                  Value <= '0;
                  Count <= '0;
                end
                KeyTare: Tare <= 1'b1;
                KeyZero: Zero <= 1'b1;
                default: ;
              endcase
            end
          end
        end
        HOLD: begin
          if (Ack) begin
            state <= EDIT;
            Valid <= 1'b0;
            Value <= '0;
            Count <= '0;
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// tb_key_entry
//
// Directed bench for key_entry with DIGITS=4. Inputs are driven on the
// falling clock edge and outputs are checked away from the rising edge.
// All expected values are hand-computed constants.

module tb_key_entry;

  logic        Clock;
  logic        Reset_n;
  logic        press;
  logic [3:0]  CodeIn;
  logic        Ack;
  logic [15:0] Value;
  logic [2:0]  Count;
  logic        Valid;
  logic        Tare;
  logic        Zero;
  logic        Err;

  int vectors = 0;
  int miscompares = 0;

  key_entry #(.DIGITS(4)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .press   (press),
    .CodeIn  (CodeIn),
    .Ack     (Ack),
    .Value   (Value),
    .Count   (Count),
    .Valid   (Valid),
    .Tare    (Tare),
    .Zero    (Zero),
    .Err     (Err)
  );

  // 10 ns clock
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One press of a key for one cycle, then release. Returns on the falling
  // edge after the action's rising edge, so results are already visible.
  task automatic applyStimulus(input logic [3:0] code);
    @(negedge Clock);
    press  = 1'b1;
    CodeIn = code;
    @(negedge Clock);
    press  = 1'b0;
    CodeIn = 4'hF;
  endtask

  // Directed sequence
  initial begin
    Reset_n = 1'b0;
    press   = 1'b0;
    CodeIn  = 4'hF;
    Ack     = 1'b0;
    #23;
    checkOutput("rst_value", 32'(Value), 32'h0);
    checkOutput("rst_count", 32'(Count), 32'h0);
    checkOutput("rst_valid", 32'(Valid), 32'h0);
    checkOutput("rst_pulses", 32'({Tare, Zero, Err}), 32'h0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Digit entry, with an explicit latency check on the second key
    applyStimulus(4'h1);
    checkOutput("d1_value", 32'(Value), 32'h0001);
    @(negedge Clock);
    press  = 1'b1;
    CodeIn = 4'h2;
    #1;
    checkOutput("d2_before_edge", 32'(Value), 32'h0001);
    @(posedge Clock);
    #1;
    checkOutput("d2_after_edge", 32'(Value), 32'h0012);
    @(negedge Clock);
    press  = 1'b0;
    applyStimulus(4'h3);
    checkOutput("d123_value", 32'(Value), 32'h0123);
    checkOutput("d123_count", 32'(Count), 32'h3);

    applyStimulus(4'hC);
    checkOutput("clear_value", 32'(Value), 32'h0);
    checkOutput("clear_count", 32'(Count), 32'h0);
    checkOutput("clear_err", 32'(Err), 32'h0);

    // Overflow, then backspace
    applyStimulus(4'h9);
    applyStimulus(4'h8);
    applyStimulus(4'h7);
    applyStimulus(4'h6);
    checkOutput("full_value", 32'(Value), 32'h9876);
    checkOutput("full_count", 32'(Count), 32'h4);
    checkOutput("full_err", 32'(Err), 32'h0);
    applyStimulus(4'h5);
    checkOutput("ovf_err", 32'(Err), 32'h1);
    checkOutput("ovf_value", 32'(Value), 32'h9876);
    checkOutput("ovf_count", 32'(Count), 32'h4);
    @(negedge Clock);
    checkOutput("ovf_err_drop", 32'(Err), 32'h0);
    applyStimulus(4'hA);
    checkOutput("bs_value", 32'(Value), 32'h0987);
    checkOutput("bs_count", 32'(Count), 32'h3);
    checkOutput("bs_err", 32'(Err), 32'h0);
    applyStimulus(4'hC);

    // Errors on an empty buffer
    applyStimulus(4'hA);
    checkOutput("empty_bs_err", 32'(Err), 32'h1);
    checkOutput("empty_bs_count", 32'(Count), 32'h0);
    @(negedge Clock);
    checkOutput("empty_bs_err_drop", 32'(Err), 32'h0);
    applyStimulus(4'hB);
    checkOutput("empty_enter_err", 32'(Err), 32'h1);
    checkOutput("empty_enter_valid", 32'(Valid), 32'h0);
    applyStimulus(4'hC);
    checkOutput("empty_clear_err", 32'(Err), 32'h0);

    // Commit handshake
    applyStimulus(4'h4);
    applyStimulus(4'h2);
    applyStimulus(4'hB);
    checkOutput("commit_valid", 32'(Valid), 32'h1);
    checkOutput("commit_value", 32'(Value), 32'h0042);
    checkOutput("commit_err", 32'(Err), 32'h0);
    applyStimulus(4'h7);
    checkOutput("hold_key_value", 32'(Value), 32'h0042);
    checkOutput("hold_key_count", 32'(Count), 32'h2);
    checkOutput("hold_key_err", 32'(Err), 32'h0);
    checkOutput("hold_key_valid", 32'(Valid), 32'h1);
    @(negedge Clock);
    @(negedge Clock);
    checkOutput("hold_wait_valid", 32'(Valid), 32'h1);
    @(negedge Clock);
    Ack = 1'b1;
    @(negedge Clock);
    Ack = 1'b0;
    checkOutput("ack_valid", 32'(Valid), 32'h0);
    checkOutput("ack_value", 32'(Value), 32'h0);
    checkOutput("ack_count", 32'(Count), 32'h0);

    // Ack together with a press edge: the key is consumed
    applyStimulus(4'h4);
    applyStimulus(4'hB);
    checkOutput("commit2_valid", 32'(Valid), 32'h1);
    @(negedge Clock);
    Ack    = 1'b1;
    press  = 1'b1;
    CodeIn = 4'h8;
    @(negedge Clock);
    Ack = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    press  = 1'b0;
    CodeIn = 4'hF;
    checkOutput("ackpress_valid", 32'(Valid), 32'h0);
    checkOutput("ackpress_value", 32'(Value), 32'h0);
    checkOutput("ackpress_count", 32'(Count), 32'h0);

    // Long hold acts once
    @(negedge Clock);
    press  = 1'b1;
    CodeIn = 4'h5;
    repeat (50) @(negedge Clock);
    press  = 1'b0;
    CodeIn = 4'hF;
    checkOutput("longhold_count", 32'(Count), 32'h1);
    checkOutput("longhold_value", 32'(Value), 32'h0005);

    // Command keys
    applyStimulus(4'hD);
    checkOutput("tare_pulse", 32'({Tare, Zero, Err}), 32'h4);
    @(negedge Clock);
    checkOutput("tare_drop", 32'(Tare), 32'h0);
    applyStimulus(4'hE);
    checkOutput("zero_pulse", 32'({Tare, Zero, Err}), 32'h2);
    @(negedge Clock);
    checkOutput("zero_drop", 32'(Zero), 32'h0);
    applyStimulus(4'hF);
    checkOutput("codef_pulses", 32'({Tare, Zero, Err}), 32'h0);
    checkOutput("codef_value", 32'(Value), 32'h0005);
    checkOutput("codef_count", 32'(Count), 32'h1);

    // Asynchronous reset in HOLD, with the key still held afterwards
    applyStimulus(4'h6);
    applyStimulus(4'hB);
    checkOutput("commit3_valid", 32'(Valid), 32'h1);
    checkOutput("commit3_value", 32'(Value), 32'h0056);
    @(negedge Clock);
    #2;
    Reset_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(Valid), 32'h0);
    checkOutput("async_value", 32'(Value), 32'h0);
    checkOutput("async_count", 32'(Count), 32'h0);
    press  = 1'b1;
    CodeIn = 4'h3;
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    checkOutput("held_after_rst_value", 32'(Value), 32'h0003);
    checkOutput("held_after_rst_count", 32'(Count), 32'h1);
    @(negedge Clock);
    checkOutput("held_after_rst_once", 32'(Count), 32'h1);
    press  = 1'b0;
    CodeIn = 4'hF;

    // Back-to-back presses with one low cycle between them
    applyStimulus(4'h7);
    applyStimulus(4'h8);
    checkOutput("b2b_value", 32'(Value), 32'h0378);
    checkOutput("b2b_count", 32'(Count), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
